// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: owns the oversample edge counter and bit counter, drives the
// per-stage enables and decides whether a finished frame is accepted or dropped.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRSC_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic              par_en,
  input  logic [PRSC_W-1:0] prescale,
  input  logic              strt_glitch,
  input  logic              par_err,
  input  logic              stp_err,
  output logic              dat_samp_en,
  output logic              done,
  output logic [PRSC_W-1:0] edge_cnt,
  output logic              strt_chk_en,
  output logic              deser_en,
  output logic              par_chk_en,
  output logic              stp_chk_en,
  output logic              data_valid,
  output logic              frame_err,
  output logic              cfg_err,
  output logic              rx_busy
);

  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [PRSC_W-1:0] edge_q, edge_d;
  logic [PRSC_W-1:0] prsc_q, prsc_d;
  logic              par_en_q, par_en_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic              data_valid_q, data_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              cfg_err_q, cfg_err_d;

  logic cfg_legal;
  logic bit_end;
  logic frame_bad;

  assign cfg_legal = (prescale == PRSC_W'(8)) || (prescale == PRSC_W'(16)) ||
                     (prescale == PRSC_W'(32));
  assign bit_end   = (state_q != StIdle) && (edge_q == prsc_q - PRSC_W'(1));
  // Parity result is only meaningful when the frame was started with parity enabled.
  assign frame_bad = (par_en_q & par_err) | stp_err;

  always_comb begin
    state_d      = state_q;
    prsc_d       = prsc_q;
    par_en_d     = par_en_q;
    bit_d        = bit_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    // Wrapping at bit_end also yields edge 0 on every START entry.
    edge_d       = ((state_q != StIdle) && !bit_end) ? edge_q + PRSC_W'(1) : '0;

    case (state_q)
      StIdle: begin
        if (!rx_in && cfg_legal) begin
          state_d  = StStart;
          prsc_d   = prescale;
          par_en_d = par_en;
        end
      end
      StStart: begin
        if (bit_end) begin
          if (strt_glitch) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            bit_d   = '0;
          end
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == LastBit) begin
            state_d = par_en_q ? StParity : StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          data_valid_d = !frame_bad;
          frame_err_d  = frame_bad;
          state_d      = rx_in ? StIdle : StStart;
        end
      end
      default: state_d = StIdle;
    endcase

    cfg_err_d = (state_d == StIdle) && !cfg_legal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      edge_q       <= '0;
      prsc_q       <= '0;
      par_en_q     <= 1'b0;
      bit_q        <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_q       <= edge_d;
      prsc_q       <= prsc_d;
      par_en_q     <= par_en_d;
      bit_q        <= bit_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign edge_cnt    = edge_q;
  // Fires after the three majority samples around mid-bit.
  assign done        = (state_q != StIdle) && (edge_q == (prsc_q >> 1) + PRSC_W'(1));
  assign dat_samp_en = (state_q != StIdle);
  assign rx_busy     = (state_q != StIdle);
  assign strt_chk_en = (state_q == StStart);
  assign deser_en    = (state_q == StData);
  assign par_chk_en  = (state_q == StParity);
  assign stp_chk_en  = (state_q == StStop);
  assign data_valid  = data_valid_q;
  assign frame_err   = frame_err_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl: frames are built from bit/cycle arithmetic and the
// expected accept/drop pulse is queued for a monitor that checks kind and arrival cycle.
module tb_uart_rx_ctrl;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_in = 1'b1;
  logic          par_en = 1'b0;
  logic [PW-1:0] prescale = 6'd16;
  logic          strt_glitch = 1'b0;
  logic          par_err = 1'b0;
  logic          stp_err = 1'b0;
  logic          dat_samp_en, done, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
  logic          data_valid, frame_err, cfg_err, rx_busy;
  logic [PW-1:0] edge_cnt;

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRSC_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .par_en      (par_en),
    .prescale    (prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .dat_samp_en (dat_samp_en),
    .done        (done),
    .edge_cnt    (edge_cnt),
    .strt_chk_en (strt_chk_en),
    .deser_en    (deser_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .cfg_err     (cfg_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit is_err;
    int at;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [31:0] status();
    return 32'({edge_cnt, done, dat_samp_en, rx_busy, strt_chk_en, deser_en, par_chk_en,
                stp_chk_en, cfg_err});
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({data_valid, frame_err, status()});
  endfunction

  // Expected status in cycle t after START entry: bit index and oversample index by division.
  function automatic logic [31:0] exp_frame(input int t, input int p, input bit pe);
    int b;
    int e;
    int len_bits;
    b = t / p;
    e = t % p;
    len_bits = 10 + int'(pe);
    return 32'({PW'(e), (e == p / 2 + 1), 1'b1, 1'b1, (b == 0), (b >= 1 && b <= DW),
                (pe && b == DW + 1), (b == len_bits - 1), 1'b0});
  endfunction

  function automatic logic line_bit(input logic [7:0] d, input int b, input bit pe,
                                    input bit bad_par, input bit bad_stop);
    if (b == 0) return 1'b0;
    if (b <= DW) return d[b-1];
    if (pe && b == DW + 1) return (^d) ^ bad_par;
    return !bad_stop;
  endfunction

  // Caller is positioned just after a negedge with the DUT idle, or at the final stop cycle
  // of a chained frame. abort_t >= 0 asserts reset at that frame cycle instead of finishing.
  task automatic send_frame(input logic [7:0] data, input int p, input bit pe,
                            input bit bad_par, input bit bad_stop, input bit chain,
                            input int abort_t);
    int   len;
    exp_t e;
    len = (10 + int'(pe)) * p;
    prescale = PW'(p);
    par_en = pe;
    rx_in = 1'b0;
    if (abort_t < 0) begin
      e.is_err = (bad_par && pe) || bad_stop;
      e.at = cyc + 1 + len;
      sb_q.push_back(e);
    end
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      check("frame_status", status(), exp_frame(t, p, pe));
      if (t == abort_t) begin
        rst = 1'b1;
        #1;
        check("reset_mid_frame", all_outs(), 32'd0);
        rx_in = 1'b1;
        prescale = PW'(p);
        par_en = pe;
        strt_glitch = 1'b0;
        par_err = 1'b0;
        stp_err = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_held", all_outs(), 32'd0);
        rst = 1'b0;
        return;
      end
      rx_in = line_bit(data, t / p, pe, bad_par, bad_stop);
      strt_glitch = (t == p - 1) ? 1'b0 : 1'($urandom);
      if (t == len - 1) begin
        rx_in = !chain;
        par_err = bad_par;
        stp_err = bad_stop;
        prescale = PW'(p);
        par_en = pe;
      end else begin
        par_err = 1'($urandom);
        stp_err = 1'($urandom);
        prescale = PW'($urandom);
        par_en = 1'($urandom);
      end
    end
  endtask

  task automatic send_glitch(input int p);
    prescale = PW'(p);
    par_en = 1'($urandom);
    rx_in = 1'b0;
    for (int t = 0; t <= p; t++) begin
      @(negedge clk);
      if (t < p) check("glitch_status", status(), exp_frame(t, p, 1'b0));
      else check("glitch_idle", all_outs(), 32'd0);
      if (t == 2) rx_in = 1'b1;
      strt_glitch = (t == p - 1) ? 1'b1 : 1'($urandom);
      par_err = 1'($urandom);
      stp_err = 1'($urandom);
    end
    strt_glitch = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: every accept/drop pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0 && sb_q[0].at < cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL pulse_missing: no pulse arrived, expected at cycle %0d (now %0d)",
               sb_q[0].at, cyc);
      void'(sb_q.pop_front());
    end
    if (data_valid || frame_err) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 32'({data_valid, frame_err}), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_kind", 32'({data_valid, frame_err}), e.is_err ? 32'd1 : 32'd2);
        check("pulse_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  initial begin
    int  p;
    bit  pe;
    bit  chain;
    bit  prev_chain;
    int  bad_cfg[7];

    repeat (3) @(negedge clk);
    check("reset_state", all_outs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_release", all_outs(), 32'd0);

    // T1: P=8, no parity, 0xA5 accepted 80 cycles after START entry
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(2);

    // T2: P=16, parity with wrong parity bit -> dropped
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    idle(2);
    check("idle_after_drop", all_outs(), 32'd0);

    // T3: start glitch aborts at the first bit end
    send_glitch(8);
    idle(2);

    // T4: back-to-back frames at P=32
    send_frame(8'h00, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(2);

    // T5: illegal prescale blocks start while the line is low
    bad_cfg = '{12, 0, 4, 15, 17, 24, 63};
    rx_in = 1'b0;
    foreach (bad_cfg[i]) begin
      prescale = PW'(bad_cfg[i]);
      repeat (2) @(negedge clk);
      check("cfg_err_illegal", 32'(cfg_err), 32'd1);
      check("busy_illegal", 32'(rx_busy), 32'd0);
    end
    send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(2);

    // T6: reset in the middle of data bit 4, then a clean frame
    send_frame(8'h96, 16, 1'b0, 1'b0, 1'b0, 1'b0, 5 * 16 + 8);
    @(negedge clk);
    check("idle_after_reset", all_outs(), 32'd0);
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(2);

    // Stop-bit error without parity, and parity error ignored when parity is off
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    idle(2);
    send_frame(8'h7E, 8, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    idle(2);

    p = 16;
    pe = 1'b0;
    prev_chain = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!prev_chain) begin
        case ($urandom_range(2))
          0:       p = 8;
          1:       p = 16;
          default: p = 32;
        endcase
        pe = 1'($urandom);
      end
      chain = (i < 19) && ($urandom_range(3) == 0);
      send_frame(8'($urandom), p, pe, $urandom_range(3) == 0, $urandom_range(3) == 0,
                 chain, -1);
      if (!chain) idle($urandom_range(4, 1));
      prev_chain = chain;
    end

    idle(5);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
